// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V subsystem: loader state encoding,
// default instruction-memory depth and program-header length.
package riscv_pkg;

   localparam int LDR_DEPTH     = 64;
   localparam int LDR_HDR_BYTES = 2;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR0,
      LD_HDR1,
      LD_DATA,
      LD_RUN,
      LD_ERR
   } ld_state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; the finished word and
// its one-cycle valid flag are registered so they appear the cycle after byte 3.
module byte_packer (
   input  logic        CLK,
   input  logic        RST,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_last,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;

   assign word_last = byte_valid && (cnt_q == 2'd3);

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (byte_valid) begin
         cnt_d = cnt_q + 2'd1;
         // Byte 3 bypasses the shift register so the word register only
         // changes when a complete word is ready.
         if (word_last) begin
            word_d  = {byte_data, shift_q};
            valid_d = 1'b1;
         end else begin
            shift_d = {byte_data, shift_q[23:8]};
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_valid = valid_q;
   assign word       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program from a byte link into instruction memory,
// then releases the core from reset; rejects programs larger than DEPTH.
module prog_loader
   import riscv_pkg::*;
#(
   parameter int DEPTH  = LDR_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = 8 * LDR_HDR_BYTES;

   ld_state_e         state_q, state_d;
   logic [7:0]        cnt_lo_q, cnt_lo_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  n_hdr;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic              accept;
   logic              pk_valid;
   logic              pk_last;
   logic [31:0]       pk_word;

   assign in_ready = (state_q == LD_HDR0) || (state_q == LD_HDR1) || (state_q == LD_DATA);
   assign accept   = in_valid && in_ready;
   assign n_hdr    = {in_data, cnt_lo_q};

   byte_packer u_packer (
      .CLK        (CLK),
      .RST        (RST),
      .byte_valid (accept && (state_q == LD_DATA)),
      .byte_data  (in_data),
      .word_last  (pk_last),
      .word_valid (pk_valid),
      .word       (pk_word)
   );

   always_comb begin
      state_d  = state_q;
      cnt_lo_d = cnt_lo_q;
      n_d      = n_q;
      wcnt_d   = wcnt_q;
      addr_d   = addr_q;
      done_d   = (state_q == LD_RUN);
      unique case (state_q)
         LD_IDLE: state_d = LD_HDR0;
         LD_HDR0: begin
            if (accept) begin
               cnt_lo_d = in_data;
               state_d  = LD_HDR1;
            end
         end
         LD_HDR1: begin
            if (accept) begin
               n_d    = n_hdr;
               wcnt_d = '0;
               if (n_hdr == '0)                    state_d = LD_RUN;
               else if (n_hdr > CNT_W'(DEPTH))     state_d = LD_ERR;
               else                                state_d = LD_DATA;
            end
         end
         LD_DATA: begin
            // Address is latched alongside the packed word so both land on
            // the write cycle; RUN is entered together with the last pulse.
            if (pk_last) begin
               addr_d = wcnt_q[ADDR_W-1:0];
               wcnt_d = wcnt_q + CNT_W'(1);
               if (wcnt_q + CNT_W'(1) == n_q) state_d = LD_RUN;
            end
         end
         LD_RUN:  state_d = LD_RUN;
         LD_ERR:  state_d = LD_ERR;
         default: state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= LD_IDLE;
         cnt_lo_q <= '0;
         n_q      <= '0;
         wcnt_q   <= '0;
         addr_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_lo_q <= cnt_lo_d;
         n_q      <= n_d;
         wcnt_q   <= wcnt_d;
         addr_q   <= addr_d;
         done_q   <= done_d;
      end
   end

   assign imem_we    = pk_valid;
   assign imem_addr  = addr_q;
   assign imem_wdata = pk_word;
   assign core_rst_n = done_q;
   assign done       = done_q;
   assign err        = (state_q == LD_ERR);

endmodule
